seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares a single 4-bit-to-7-segment decoder among DIGITS common-anode digits. It sequences digit selection, feeds the selected nibble and blanking control to the decoder, and drives active-low anodes with a blanking gap between digits to suppress ghosting. Display data is double-buffered and takes effect only at frame boundaries, so a digit set never tears mid-frame. It sits between the board-level value/status logic and the seg_decoder/anode pins.

## Interface
- DIGITS, 4: number of multiplexed digits, legal 1..8.
- CLK_DIV, 100000: clock cycles per digit slot, legal ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off, legal 0..CLK_DIV-1.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle strobe; stages data_in/dp_in/en_in.
- data_in  in  4*DIGITS  nibble per digit, digit i = bits [4i+3:4i].
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- en_in  in  DIGITS  digit enable, 1 = displayed.
- nib_out  out  4  nibble to the decoder `in`.
- dec_blank  out  1  to the decoder `rst`; 1 = all segments off.
- dp_n  out  1  active-low decimal point segment.
- an  out  DIGITS  active-low anode selects; at most one bit low.
- frame_tick  out  1  one-cycle pulse at each frame start.

## Operation
- State: slot counter cnt (0..CLK_DIV-1), digit index idx (0..DIGITS-1), staged regs (data/dp/en), shadow regs (data/dp/en), pending flag.
- Each cycle, cnt increments. At cnt==CLK_DIV-1, cnt→0 and idx→idx+1. idx wraps from DIGITS-1 to 0; this wrap is the frame boundary.
- Slot phases:
  - BLANK: cnt < BLANK_CYC.
  - DRIVE: cnt ≥ BLANK_CYC.
  - BLANK_CYC=0 means there is no BLANK phase.
- BLANK outputs: an all 1s, dec_blank=1, dp_n=1, nib_out holds the current idx's shadow nibble.
- DRIVE with shadow en[idx]=1: an[idx]=0, all other bits 1; dec_blank=0; nib_out=shadow nibble idx; dp_n=~shadow dp[idx].
- DRIVE with shadow en[idx]=0: behaves as BLANK. The slot time is still consumed, so refresh rate does not depend on the enables.
- load: staged ← inputs and pending ← 1. A later load before the boundary overwrites the staged regs; the last one wins.
- Frame boundary with pending=1: shadow ← staged, pending ← 0.
- load in the same cycle as a boundary:
  - The boundary copies the previously staged contents to shadow.
  - The new inputs go to staged and pending stays 1.
  - The new data is applied at the following boundary.
- Reset mid-operation: all state returns to reset values on the next edge, and any staged data is discarded.

## Timing
- All outputs are registered and reflect the cnt/idx/shadow state of the previous cycle (1-cycle latency).
- Reset values:
  - an = all 1s, dec_blank = 1, dp_n = 1, nib_out = 0, frame_tick = 0.
  - cnt = 0, idx = 0, shadow and staged all 0 (all digits disabled), pending = 0.
- Before the first load is applied, the display is dark.
- Frame period is DIGITS*CLK_DIV cycles. Each digit's duty is (CLK_DIV-BLANK_CYC)/(DIGITS*CLK_DIV).
- First cycle out of reset (rst low at edge E0): cnt=0, idx=0, and outputs show digit 0's BLANK phase from edge E0+1.
- frame_tick is high for exactly one cycle, the same cycle in which outputs first show idx=0 with new shadow values.
  - It pulses every frame, whether or not an update occurred.
  - No frame_tick is produced for the post-reset start.
- Latency from load to visible output: at least 1 cycle and at most one frame + 1 cycle.
- No combinational path from any input to any output.

## Test plan
Parameters for all scenarios: DIGITS=4, CLK_DIV=8, BLANK_CYC=2.

- Reset: hold rst 3 cycles mid-scan after a load. Required: the next cycle shows an=4'b1111, dec_blank=1, dp_n=1, frame_tick=0, and the display stays dark for 2 frames with no load.
- Basic scan: load data_in=16'h4321, dp_in=4'b0100, en_in=4'hF. Required after the next frame_tick:
  - Digit i drives an with bit i low for 6 cycles after 2 blank cycles; nib_out=i+1.
  - dp_n=0 only while an=4'b1011.
  - Period is 32 cycles between frame_ticks.
- Disabled digit: en_in=4'b1101. Required: during slot 1, an=4'b1111 and dec_blank=1 for all 8 cycles; digits 0, 2 and 3 are unaffected.
- Tear-free update: load 16'hAAAA mid-frame, then load 16'hBBBB two cycles later. Required:
  - The current frame completes with the old values.
  - The next frame shows only B on all digits; A is never displayed.
- Load at boundary: staged=16'h1111 pending; assert load with 16'h2222 in the boundary cycle. Required: one frame of 1s, then 2s from the next frame_tick.
- No blank gap: rebuild with BLANK_CYC=0. Required: an goes low in the first cycle of every slot, and dec_blank is never 1 while all digits are enabled.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous,
// double-buffered display data and a per-slot anode blanking gap.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_in,
  output logic [3:0]          nib_out,
  output logic                dec_blank,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an,
  output logic                frame_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] st_data, sh_data;
  logic [DIGITS-1:0]   st_dp, sh_dp;
  logic [DIGITS-1:0]   st_en, sh_en;
  logic                pending;
  logic                wrapped;

  logic                slot_end;
  logic                boundary;
  logic                in_blank;
  logic                drive;
  logic [DIGITS-1:0]   an_d;
  logic [3:0]          nib_d;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BC = CW'(BLANK_CYC);
      assign in_blank = (cnt < BC);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      st_data <= '0;
      st_dp   <= '0;
      st_en   <= '0;
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      pending <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= boundary;
      if (slot_end) begin
        cnt <= '0;
        idx <= boundary ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Boundary copies the old staged set; a coincident load re-arms.
      if (boundary && pending) begin
        sh_data <= st_data;
        sh_dp   <= st_dp;
        sh_en   <= st_en;
        pending <= 1'b0;
      end
      if (load) begin
        st_data <= data_in;
        st_dp   <= dp_in;
        st_en   <= en_in;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    an_d  = '1;
    nib_d = sh_data[{idx, 2'b00} +: 4];
    drive = !in_blank && sh_en[idx];
    if (drive) an_d[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      dec_blank  <= 1'b1;
      dp_n       <= 1'b1;
      nib_out    <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      dec_blank  <= !drive;
      dp_n       <= !(drive && sh_dp[idx]);
      nib_out    <= nib_d;
      frame_tick <= wrapped;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two builds (blank gap and none) driven in
// lockstep and compared every cycle against a time-indexed model.
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int C = 8;
  localparam int B = 2;
  localparam int F = D * C;
  localparam logic [10:0] RSTV = {4'hF, 1'b1, 1'b1, 4'h0, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;

  logic [3:0] nib_a, nib_b, an_a, an_b;
  logic       blk_a, blk_b, dpn_a, dpn_b, ft_a, ft_b;

  seg_scan_ctrl #(.DIGITS(D), .CLK_DIV(C), .BLANK_CYC(B)) dut_a (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .dp_in(dp_in), .en_in(en_in), .nib_out(nib_a),
    .dec_blank(blk_a), .dp_n(dpn_a), .an(an_a), .frame_tick(ft_a)
  );

  seg_scan_ctrl #(.DIGITS(D), .CLK_DIV(C), .BLANK_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .dp_in(dp_in), .en_in(en_in), .nib_out(nib_b),
    .dec_blank(blk_b), .dp_n(dpn_b), .an(an_b), .frame_tick(ft_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int tcyc = 0;
  int last_tick = -1;
  logic [15:0] sh_d = '0, st_d = '0;
  logic [3:0]  sh_p = '0, st_p = '0, sh_e = '0, st_e = '0;
  logic        pend = 1'b0;
  logic        watch_a = 1'b0;

  // Expected {an, dec_blank, dp_n, nib, tick} for elapsed cycle nn.
  function automatic logic [10:0] expv(int nn, int blank,
      logic [15:0] d, logic [3:0] dp, logic [3:0] en);
    int cnt;
    int ix;
    logic drv;
    logic [3:0] a;
    cnt = nn % C;
    ix  = (nn / C) % D;
    drv = (cnt >= blank) && en[ix];
    a   = 4'hF;
    if (drv) a[ix] = 1'b0;
    return {a, !drv, !(drv && dp[ix]), d[ix*4 +: 4],
            (nn > 0) && (nn % F == 0)};
  endfunction

  task automatic cyc();
    logic [10:0] ea, eb;
    if (rst) begin
      ea = RSTV; eb = RSTV;
      n = 0; pend = 1'b0; last_tick = -1;
      sh_d = '0; sh_p = '0; sh_e = '0;
      st_d = '0; st_p = '0; st_e = '0;
    end else begin
      ea = expv(n, B, sh_d, sh_p, sh_e);
      eb = expv(n, 0, sh_d, sh_p, sh_e);
      if ((n % F == F - 1) && pend) begin
        sh_d = st_d; sh_p = st_p; sh_e = st_e; pend = 1'b0;
      end
      if (load) begin
        st_d = data_in; st_p = dp_in; st_e = en_in; pend = 1'b1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    tcyc++;
    load = 1'b0;
    checks++;
    assert ({an_a, blk_a, dpn_a, nib_a, ft_a} === ea) else begin
      failures++;
      $error("FAIL out_gap n=%0d got=%h exp=%h", n,
             {an_a, blk_a, dpn_a, nib_a, ft_a}, ea);
    end
    checks++;
    assert ({an_b, blk_b, dpn_b, nib_b, ft_b} === eb) else begin
      failures++;
      $error("FAIL out_nogap n=%0d got=%h exp=%h", n,
             {an_b, blk_b, dpn_b, nib_b, ft_b}, eb);
    end
    if (ft_a) begin
      if (last_tick >= 0) begin
        checks++;
        assert (tcyc - last_tick == F) else begin
          failures++;
          $error("FAIL tick_period got=%0d exp=%0d", tcyc - last_tick, F);
        end
      end
      last_tick = tcyc;
    end
    if (watch_a) begin
      checks++;
      assert (!(blk_a == 1'b0 && nib_a == 4'hA)) else begin
        failures++;
        $error("FAIL tear got=nibA shown exp=never");
      end
    end
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  // Advance until the pre-edge state is at frame position m.
  task automatic run_to(int m);
    for (int i = 0; i < 2 * F && (n % F) != m; i++) cyc();
    checks++;
    assert ((n % F) == m) else begin
      failures++;
      $error("FAIL run_to got=%0d exp=%0d", n % F, m);
    end
  endtask

  task automatic ld(logic [15:0] d, logic [3:0] p, logic [3:0] e);
    data_in = d; dp_in = p; en_in = e; load = 1'b1;
    cyc();
  endtask

  initial begin
    // Reset mid-scan after a load discards the staged data
    run(3);
    rst = 1'b0;
    run(5);
    ld(16'h9876, 4'hF, 4'hF);
    run(4);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * F + 4);

    // Basic scan
    ld(16'h4321, 4'b0100, 4'hF);
    run(3 * F);

    // Disabled digit 1
    ld(16'h4321, 4'b0100, 4'b1101);
    run(2 * F + 3);

    // Tear-free update: A then B in the same frame
    run_to(10);
    ld(16'hAAAA, 4'h0, 4'hF);
    run(1);
    watch_a = 1'b1;
    ld(16'hBBBB, 4'h0, 4'hF);
    run(2 * F + 5);
    watch_a = 1'b0;

    // Load coinciding with the frame boundary
    run_to(5);
    ld(16'h1111, 4'h0, 4'hF);
    run_to(F - 1);
    ld(16'h2222, 4'h0, 4'hF);
    run(2 * F + 3);

    // Random loads
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        data_in = 16'($urandom);
        dp_in = 4'($urandom);
        en_in = 4'($urandom);
        load = 1'b1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
